counter_n: RTL and testbench
============================

# counter_n

Parametrised modulo up/down counter built on the team's add/subtract datapath. It extends the fixed 4-bit add/sub adder into a clocked N-bit counter with:
- a programmable step and a programmable modulus,
- a selectable wrap or saturate mode,
- parallel load, and carry/borrow and error reporting.

It is the generic counting element for the counter subsystem.

## Interface
Parameters:
- N, 8, counter width in bits
- MOD, 256, count range 0..MOD-1; legal range 2 <= MOD <= 2^N
- SAT, 0, 0 = wrap modulo MOD, 1 = saturate at the range limits

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- EN  input  1  count enable
- T  input  1  direction: 0 = up (add), 1 = down (subtract)
- LD  input  1  synchronous parallel load
- D  input  N  load value
- STEP  input  N  increment/decrement amount
- Q  output  N  registered count
- Cout  output  1  registered one-cycle pulse on wrap (carry when up, borrow when down)
- TC  output  1  combinational terminal count: Q==MOD-1 when T=0, Q==0 when T=1
- ERR  output  1  registered one-cycle pulse on an illegal D or STEP

## Operation
- Priority per clock edge: rst (asynchronous) > LD > EN > hold.
- All arithmetic uses N+1 bits internally, so carry and borrow are never lost.
- Subtraction uses the T-controlled form Q + ~STEP + 1. Borrow is detected when STEP > Q.
- LD=1:
  - D < MOD: Q <= D, ERR <= 0.
  - D >= MOD: Q <= MOD-1, ERR <= 1.
  - Cout <= 0 in both cases.
- EN=1, LD=0, STEP >= MOD: Q holds, ERR <= 1, Cout <= 0.
- EN=1, LD=0, STEP=0: Q holds, Cout <= 0, ERR <= 0.
- EN=1, LD=0, STEP < MOD, up (T=0), with s = Q+STEP:
  - s < MOD: Q <= s.
  - s >= MOD and SAT=0: Q <= s-MOD, Cout <= 1.
  - s >= MOD and SAT=1: Q <= MOD-1, Cout <= 0.
- EN=1, LD=0, STEP < MOD, down (T=1):
  - STEP <= Q: Q <= Q-STEP.
  - STEP > Q and SAT=0: Q <= Q+MOD-STEP, Cout <= 1.
  - STEP > Q and SAT=1: Q <= 0, Cout <= 0.
- EN=0, LD=0: Q holds, Cout <= 0, ERR <= 0.
- When MOD = 2^N, modulo wrap reduces to plain N-bit overflow. The result must be identical to the MOD < 2^N path with MOD substituted.
- T may change on any cycle. The next edge uses the T value sampled at that edge. TC follows T combinationally.

## Timing
- Reset values: Q=0, Cout=0, ERR=0. TC equals (T==1) while in reset, because Q=0.
- rst assertion clears Q, Cout and ERR immediately, without waiting for a clock edge. This includes the middle of a count or load sequence.
- After rst deasserts, the first active edge performs a normal LD/EN operation.
- Latency is one cycle: inputs sampled at edge k appear on Q, Cout and ERR after edge k.
- Cout and ERR are high for exactly one cycle per offending or wrapping operation. They re-assert on consecutive cycles if the condition repeats.
- TC has no register stage. Its only path from Q and T is the compare logic.

## Test plan
- N=4, MOD=10, SAT=0. Reset, then EN=1, T=0, STEP=1 for 12 cycles -> Q = 1,2,…,9,0,1,2. Cout is high only in the cycle Q=0 appears. TC is high while Q=9.
- N=4, MOD=10, SAT=0. Load D=2, then EN=1, T=1, STEP=3 -> Q=9 and Cout=1 for one cycle. The next step gives Q=6 with Cout=0.
- N=4, MOD=10, SAT=1:
  - Q=8, T=0, STEP=3 -> Q=9, Cout=0; held at 9 while counting continues.
  - Q=1, T=1, STEP=3 -> Q=0, Cout=0.
- Load D=12 with MOD=10 -> Q=9, ERR high for one cycle. LD=1 and EN=1 with D=4 in the same cycle -> Q=4 (load wins), Cout=0.
- EN=1, STEP=11 with MOD=10 and Q=5 -> Q stays 5, ERR pulses once. STEP=0 -> Q stays 5, no ERR, no Cout.
- Count up from 0 with STEP=1. Assert rst between clock edges when Q=6 -> Q=0 and Cout=0 immediately, before the next edge. After release the count resumes at 1.

Source files
------------

// File: rtl/counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : counter_n
//  Description : Parametrised modulo up/down counter with programmable step,
//                wrap or saturate mode, parallel load, carry/borrow pulse,
//                error pulse and combinational terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_n #(
    parameter int N   = 8,
    parameter int MOD = 256,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         EN,
    input  logic         T,
    input  logic         LD,
    input  logic [N-1:0] D,
    input  logic [N-1:0] STEP,
    output logic [N-1:0] Q,
    output logic         Cout,
    output logic         TC,
    output logic         ERR
);

    // Modulus kept one bit wider than the count so MOD = 2^N is representable.
    localparam logic [N:0]   c_MOD = (N+1)'(MOD);
    localparam logic [N-1:0] c_MAX = N'(MOD - 1);

    logic [N-1:0] r_q;
    logic         r_cout;
    logic         r_err;

    logic [N:0]   w_q_ext;
    logic [N:0]   w_step_ext;
    logic [N:0]   w_d_ext;
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic [N-1:0] w_sum_wrap;
    logic [N-1:0] w_diff_wrap;
    logic         w_borrow;
    logic         w_ovf;
    logic         w_step_ok;
    logic         w_d_ok;
    logic [N-1:0] w_q_nxt;
    logic         w_cout_nxt;
    logic         w_err_nxt;

    // Shared N+1 bit add/subtract datapath; subtraction is Q + ~STEP + 1 so
    // the extra top bit becomes the borrow flag when STEP > Q.
    assign w_q_ext     = {1'b0, r_q};
    assign w_step_ext  = {1'b0, STEP};
    assign w_d_ext     = {1'b0, D};
    assign w_sum       = w_q_ext + w_step_ext;
    assign w_diff      = w_q_ext + ~w_step_ext + (N+1)'(1);
    assign w_borrow    = w_diff[N];
    assign w_ovf       = (w_sum >= c_MOD);
    assign w_sum_wrap  = N'(w_sum - c_MOD);
    assign w_diff_wrap = N'(w_diff + c_MOD);
    assign w_step_ok   = (w_step_ext < c_MOD);
    assign w_d_ok      = (w_d_ext < c_MOD);

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        w_q_nxt    = r_q;
        w_cout_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (LD) begin
            if (w_d_ok) begin
                w_q_nxt = D;
            end else begin
                w_q_nxt   = c_MAX;
                w_err_nxt = 1'b1;
            end
        end else if (EN) begin
            if (!w_step_ok) begin
                w_err_nxt = 1'b1;
            end else if (!T) begin
                if (!w_ovf) begin
                    w_q_nxt = w_sum[N-1:0];
                end else if (SAT) begin
                    w_q_nxt = c_MAX;
                end else begin
                    w_q_nxt    = w_sum_wrap;
                    w_cout_nxt = 1'b1;
                end
            end else begin
                if (!w_borrow) begin
                    w_q_nxt = w_diff[N-1:0];
                end else if (SAT) begin
                    w_q_nxt = '0;
                end else begin
                    w_q_nxt    = w_diff_wrap;
                    w_cout_nxt = 1'b1;
                end
            end
        end
    end

    // Count, carry and error registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_cout <= w_cout_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign Q    = r_q;
    assign Cout = r_cout;
    assign ERR  = r_err;
    // Terminal count follows T with no register stage.
    assign TC   = T ? (r_q == '0) : (r_q == c_MAX);

endmodule
`default_nettype wire

// File: tb/tb_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_n
//  Description : Scoreboard bench for counter_n; three instances share one
//                stimulus stream: modulus 10 wrap, modulus 10 saturate and
//                modulus 16 wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_n;

    localparam int NB = 3;

    typedef struct {
        int q;
        bit c;
        bit e;
        bit tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       t   = 1'b0;
    logic       ld  = 1'b0;
    logic [3:0] d   = '0;
    logic [3:0] stp = '0;

    logic [3:0]    q_o [NB];
    logic [NB-1:0] c_o;
    logic [NB-1:0] tc_o;
    logic [NB-1:0] e_o;

    int mods [NB] = '{10, 10, 16};
    bit sats [NB] = '{1'b0, 1'b1, 1'b0};
    int mq   [NB] = '{0, 0, 0};

    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    int n_checks = 0;
    int n_errors = 0;

    counter_n #(.N(4), .MOD(10), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .EN(en), .T(t), .LD(ld), .D(d), .STEP(stp),
        .Q(q_o[0]), .Cout(c_o[0]), .TC(tc_o[0]), .ERR(e_o[0])
    );

    counter_n #(.N(4), .MOD(10), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .EN(en), .T(t), .LD(ld), .D(d), .STEP(stp),
        .Q(q_o[1]), .Cout(c_o[1]), .TC(tc_o[1]), .ERR(e_o[1])
    );

    counter_n #(.N(4), .MOD(16), .SAT(1'b0)) u_full (
        .clk(clk), .rst(rst), .EN(en), .T(t), .LD(ld), .D(d), .STEP(stp),
        .Q(q_o[2]), .Cout(c_o[2]), .TC(tc_o[2]), .ERR(e_o[2])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the counting rules.
    task automatic model(input int mod, input bit sat, inout int q,
                         input bit l, input bit e, input bit dir,
                         input int dv, input int sv,
                         output bit co, output bit er);
        int s;
        co = 1'b0;
        er = 1'b0;
        if (l) begin
            if (dv < mod) q = dv;
            else begin q = mod - 1; er = 1'b1; end
        end else if (e) begin
            if (sv >= mod) er = 1'b1;
            else if (!dir) begin
                s = q + sv;
                if (s < mod) q = s;
                else if (sat) q = mod - 1;
                else begin q = s - mod; co = 1'b1; end
            end else begin
                s = q - sv;
                if (s >= 0) q = s;
                else if (sat) q = 0;
                else begin q = s + mod; co = 1'b1; end
            end
        end
    endtask

    // Drive one operation at the falling edge and log its expected result.
    task automatic drive(input bit l, input bit e, input bit dir,
                         input int dv, input int sv);
        exp_t x;
        bit co, er;
        @(negedge clk);
        ld  = l;
        en  = e;
        t   = dir;
        d   = 4'(dv);
        stp = 4'(sv);
        for (int i = 0; i < NB; i++) begin
            model(mods[i], sats[i], mq[i], l, e, dir, dv, sv, co, er);
            x.q  = mq[i];
            x.c  = co;
            x.e  = er;
            x.tc = dir ? (mq[i] == 0) : (mq[i] == mods[i] - 1);
            if (i == 0) sb0.push_back(x);
            else if (i == 1) sb1.push_back(x);
            else sb2.push_back(x);
        end
    endtask

    task automatic check_idx(input int i, input exp_t x);
        check($sformatf("Q[%0d]", i), int'(q_o[i]), x.q);
        check($sformatf("Cout[%0d]", i), int'(c_o[i]), int'(x.c));
        check($sformatf("ERR[%0d]", i), int'(e_o[i]), int'(x.e));
        check($sformatf("TC[%0d]", i), int'(tc_o[i]), int'(x.tc));
    endtask

    // Assert reset between edges and confirm outputs clear before any edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NB; i++) begin
            check($sformatf("rstQ[%0d]", i), int'(q_o[i]), 0);
            check($sformatf("rstCout[%0d]", i), int'(c_o[i]), 0);
            check($sformatf("rstERR[%0d]", i), int'(e_o[i]), 0);
            mq[i] = 0;
        end
        @(negedge clk);
        en  = 1'b0;
        ld  = 1'b0;
        rst = 1'b0;
    endtask

    // Monitor: compare every clocked result against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin x = sb0.pop_front(); check_idx(0, x); end
            if (sb1.size() > 0) begin x = sb1.pop_front(); check_idx(1, x); end
            if (sb2.size() > 0) begin x = sb2.pop_front(); check_idx(2, x); end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #1;
        rst = 1'b1;
        #1;
        t = 1'b0;
        #1;
        for (int i = 0; i < NB; i++) begin
            check($sformatf("initQ[%0d]", i), int'(q_o[i]), 0);
            check($sformatf("initCout[%0d]", i), int'(c_o[i]), 0);
            check($sformatf("initERR[%0d]", i), int'(e_o[i]), 0);
            check($sformatf("initTCup[%0d]", i), int'(tc_o[i]), 0);
        end
        t = 1'b1;
        #1;
        for (int i = 0; i < NB; i++)
            check($sformatf("initTCdn[%0d]", i), int'(tc_o[i]), 1);
        @(negedge clk);
        t   = 1'b0;
        rst = 1'b0;

        // Up-count by one through the wrap point.
        for (int k = 0; k < 12; k++) drive(1'b0, 1'b1, 1'b0, 0, 1);
        // Load 2 then count down by 3 across the borrow.
        drive(1'b1, 1'b0, 1'b0, 2, 0);
        drive(1'b0, 1'b1, 1'b1, 0, 3);
        drive(1'b0, 1'b1, 1'b1, 0, 3);
        // Saturation toward the top and the bottom.
        drive(1'b1, 1'b0, 1'b0, 8, 0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, 0, 3);
        drive(1'b1, 1'b0, 1'b0, 1, 0);
        drive(1'b0, 1'b1, 1'b1, 0, 3);
        drive(1'b0, 1'b1, 1'b1, 0, 3);
        // Illegal load value, then load colliding with enable.
        drive(1'b1, 1'b0, 1'b0, 12, 0);
        drive(1'b1, 1'b1, 1'b0, 4, 3);
        // Illegal step, repeated illegal step, and zero step.
        drive(1'b1, 1'b0, 1'b0, 5, 0);
        drive(1'b0, 1'b1, 1'b0, 0, 11);
        drive(1'b0, 1'b1, 1'b1, 0, 11);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 0, 1);
        // Reset in the middle of a count at Q=6, then resume.
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 1'b0, 0, 1);
        async_reset();
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, 0, 1);

        // Randomised operations with occasional asynchronous resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(99) < 3) begin
                async_reset();
            end else begin
                drive($urandom_range(99) < 10, $urandom_range(99) < 85,
                      1'($urandom_range(1)), int'($urandom_range(15)),
                      ($urandom_range(3) == 0) ? int'($urandom_range(15))
                                               : int'($urandom_range(4)));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("drain", sb0.size() + sb1.size() + sb2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
